// File: rtl/logic_unit_pipe.sv
// Registered two-operand bitwise logic slice with valid/ready handshake,
// result chaining, zero/parity flags and a saturating accepted-beat counter.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOTA = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    logic [WIDTH-1:0] last_res;
    logic [WIDTH-1:0] eff_b;
    logic [WIDTH-1:0] result;
    logic             accept;

    // Single output register: a new beat may enter whenever the held one leaves.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        eff_b  = in_chain ? last_res : in_b;
        result = '0;
        case (op_e'(in_op))
            OP_AND:  result = in_a & eff_b;
            OP_OR:   result = in_a | eff_b;
            OP_NOTA: result = ~in_a;
            OP_NAND: result = ~(in_a & eff_b);
            OP_NOR:  result = ~(in_a | eff_b);
            OP_XOR:  result = in_a ^ eff_b;
            OP_XNOR: result = ~(in_a ^ eff_b);
            OP_PASS: result = in_a;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_zero   <= 1'b0;
            out_parity <= 1'b0;
            last_res   <= '0;
            op_count   <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= result;
            out_zero   <= (result == '0);
            out_parity <= ^result;
            last_res   <= result;
            if (op_count != '1)
                op_count <= op_count + CNT_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
